// File: rtl/wb_quad_velocity_pkg.sv
// wb_quad_pkg: shared constants for the quadrature velocity peripheral.
// Contents: register word offsets, CTRL/STATUS bit positions, minimum window,
// Wishbone slave FSM state encoding, and a window clamp helper.
package wb_quad_pkg;

   // Register map, decoded from i_wb_addr[1:0]
   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_PERIOD   = 2'd1;
   localparam logic [1:0] ADDR_VELOCITY = 2'd2;
   localparam logic [1:0] ADDR_STATUS   = 2'd3;

   // CTRL bits
   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   // STATUS bits
   localparam int STATUS_VALID_BIT   = 0;
   localparam int STATUS_OVERRUN_BIT = 1;

   // Shortest window the hardware accepts; smaller writes are raised to this
   localparam logic [31:0] MIN_PERIOD = 32'd2;

   // Wishbone slave FSM encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   function automatic logic [31:0] clamp_period(input logic [31:0] val);
      return (val < MIN_PERIOD) ? MIN_PERIOD : val;
   endfunction

endpackage

// File: rtl/wb_quad_velocity_if.sv
// wb_quad_velocity_if: Wishbone classic bus bundle for the velocity peripheral.
// Signals keep the slave-side names (i_* driven by master, o_* driven by slave).
// Modports: master drives cyc/stb/we/addr/data/sel; slave drives ack/stall/data.
interface wb_quad_velocity_if;

   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [29:0] i_wb_addr;
   logic [31:0] i_wb_data;
   logic [3:0]  i_wb_sel;
   logic        o_wb_ack;
   logic        o_wb_stall;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_ack, o_wb_stall, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_ack, o_wb_stall, o_wb_data
   );

endinterface

// File: rtl/wb_quad_velocity_timer.sv
// quad_window_timer: reloadable down-counter that marks the end of each window.
// Latency: tick_o is combinational on the cycle the count sits at zero while enabled.
// Backpressure: none; ports i_clk, i_reset, en_i, load_i, load_val_i[31:0], tick_o.
module quad_window_timer
   import wb_quad_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        en_i,
   input  logic        load_i,
   input  logic [31:0] load_val_i,
   output logic        tick_o
);

   logic [31:0] count_q, count_d;

   // An explicit load (enable rising) restarts the window and never ticks.
   assign tick_o = en_i & ~load_i & (count_q == 32'd0);

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         // Reload on tick so successive ticks are exactly load_val_i+1 cycles apart
         count_d = tick_o ? load_val_i : (count_q - 32'd1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wb_quad_velocity.sv
// wb_quad_velocity: Wishbone slave sampling encoder position delta every PERIOD cycles.
// Latency: access accepted in IDLE, ack + registered read data exactly one cycle later.
// Backpressure: o_wb_stall high during the ack cycle; ports i_clk, i_reset, wb (slave), i_count, o_int.
module wb_quad_velocity
   import wb_quad_pkg::*;
#(
   parameter logic [31:0] DEFAULT_PERIOD = 32'd100000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   wb_quad_velocity_if.slave  wb,
   input  logic [31:0]        i_count,
   output logic               o_int
);

   logic [0:0]  state_q, state_d;
   logic        enable_q, enable_d;
   logic        irq_en_q, irq_en_d;
   logic [31:0] period_q, period_d;
   logic [31:0] velocity_q, velocity_d;
   logic [31:0] last_count_q, last_count_d;
   logic        valid_q, valid_d;
   logic        overrun_q, overrun_d;
   logic [31:0] rdata_q, rdata_d;

   logic        acc;
   logic        wr;
   logic        rd;
   logic [1:0]  addr;
   logic [31:0] rd_mux;
   logic        enable_rise;
   logic        tick;
   logic        valid_clr;
   logic        overrun_clr;
   logic        unused_bus;

   // Only the low word-address bits are decoded and sel is ignored.
   assign unused_bus = ^{wb.i_wb_sel, wb.i_wb_addr[29:2]};

   assign addr = wb.i_wb_addr[1:0];
   assign acc  = (state_q == ST_IDLE) & wb.i_wb_cyc & wb.i_wb_stb;
   assign wr   = acc & wb.i_wb_we;
   assign rd   = acc & ~wb.i_wb_we;

   assign enable_rise = wr & (addr == ADDR_CTRL) & wb.i_wb_data[CTRL_ENABLE_BIT] & ~enable_q;

   quad_window_timer u_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .en_i       (enable_q),
      .load_i     (enable_rise),
      .load_val_i (period_q - 32'd1),
      .tick_o     (tick)
   );

   // Software-side clears of the sample flags; a new sample on the same edge overrides them.
   assign valid_clr   = (rd & (addr == ADDR_VELOCITY)) |
                        (wr & (addr == ADDR_STATUS) & wb.i_wb_data[STATUS_VALID_BIT]);
   assign overrun_clr = wr & (addr == ADDR_STATUS) & wb.i_wb_data[STATUS_OVERRUN_BIT];

   always_comb begin
      rd_mux = 32'd0;
      case (addr)
         ADDR_CTRL:     rd_mux = {30'd0, irq_en_q, enable_q};
         ADDR_PERIOD:   rd_mux = period_q;
         ADDR_VELOCITY: rd_mux = velocity_q;
         ADDR_STATUS:   rd_mux = {30'd0, overrun_q, valid_q};
         default:       rd_mux = 32'd0;
      endcase
   end

   always_comb begin
      state_d      = ST_IDLE;
      enable_d     = enable_q;
      irq_en_d     = irq_en_q;
      period_d     = period_q;
      velocity_d   = velocity_q;
      last_count_d = last_count_q;
      valid_d      = valid_q;
      overrun_d    = overrun_q;
      rdata_d      = 32'd0;

      if (state_q == ST_IDLE && wb.i_wb_cyc && wb.i_wb_stb) begin
         state_d = ST_ACK;
      end

      // Read data is captured from pre-edge state, so a same-cycle sample
      // returns the old VELOCITY.
      if (rd) begin
         rdata_d = rd_mux;
      end

      if (wr && addr == ADDR_CTRL) begin
         enable_d = wb.i_wb_data[CTRL_ENABLE_BIT];
         irq_en_d = wb.i_wb_data[CTRL_IRQ_EN_BIT];
      end

      // The timer picks this up at its next reload, so the running window keeps its length.
      if (wr && addr == ADDR_PERIOD) begin
         period_d = clamp_period(wb.i_wb_data);
      end

      if (enable_rise) begin
         last_count_d = i_count;
      end

      if (valid_clr) begin
         valid_d = 1'b0;
      end
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end

      if (tick) begin
         // Modular subtraction keeps the delta correct across counter wrap.
         velocity_d   = i_count - last_count_q;
         last_count_d = i_count;
         valid_d      = 1'b1;
         if (valid_q && !valid_clr) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         enable_q     <= 1'b0;
         irq_en_q     <= 1'b0;
         period_q     <= DEFAULT_PERIOD;
         velocity_q   <= 32'd0;
         last_count_q <= 32'd0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
         rdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         irq_en_q     <= irq_en_d;
         period_q     <= period_d;
         velocity_q   <= velocity_d;
         last_count_q <= last_count_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
         rdata_q      <= rdata_d;
      end
   end

   assign wb.o_wb_ack   = (state_q == ST_ACK);
   assign wb.o_wb_stall = (state_q != ST_IDLE);
   assign wb.o_wb_data  = rdata_q;
   assign o_int         = irq_en_q & valid_q;

endmodule

// File: tb/tb_wb_quad_velocity.sv
// tb_wb_quad_velocity: directed bench for wb_quad_velocity.
// Bus reads push expected data into a scoreboard queue; a monitor pops on each ack.
// Window timing and interrupt level are checked inline against hand-computed edges.
module tb_wb_quad_velocity;

   logic        clk;
   logic        rst;
   logic [31:0] i_count;
   logic        o_int;
   logic [31:0] step;

   wb_quad_velocity_if wb();

   wb_quad_velocity dut (
      .i_clk   (clk),
      .i_reset (rst),
      .wb      (wb),
      .i_count (i_count),
      .o_int   (o_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dc;
      logic [31:0] val;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   n_chk;
   int   n_fail;
   int   edge_n;
   int   last_acc;
   int   ebase;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: advance past the next posedge, then move the encoder count.
   task automatic cycle();
      @(negedge clk);
      edge_n++;
      i_count = i_count + step;
   endtask

   task automatic goto(input int target);
      while (edge_n < target) cycle();
   endtask

   task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string nm);
      exp_t x;
      x.dc  = we;
      x.val = exp_rd;
      x.nm  = nm;
      exp_q.push_back(x);
      wb.i_wb_cyc  = 1'b1;
      wb.i_wb_stb  = 1'b1;
      wb.i_wb_we   = we;
      wb.i_wb_addr = {28'd0, a};
      wb.i_wb_data = d;
      cycle();
      last_acc     = edge_n;
      wb.i_wb_cyc  = 1'b0;
      wb.i_wb_stb  = 1'b0;
      wb.i_wb_we   = 1'b0;
      chk({nm, "_ack"}, {31'd0, wb.o_wb_ack}, 32'd1);
      chk({nm, "_stall"}, {31'd0, wb.o_wb_stall}, 32'd1);
      cycle();
      chk({nm, "_ack_drop"}, {31'd0, wb.o_wb_ack}, 32'd0);
      chk({nm, "_data_idle"}, wb.o_wb_data, 32'd0);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      bus(1'b0, a, 32'd0, exp, nm);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input string nm);
      bus(1'b1, a, d, 32'd0, nm);
   endtask

   // Scoreboard monitor: samples just after each posedge, when ack/data have settled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (wb.o_wb_ack) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ack: ack with data %h, none expected", wb.o_wb_data);
            end else begin
               e_mon = exp_q.pop_front();
               if (!e_mon.dc) chk(e_mon.nm, wb.o_wb_data, e_mon.val);
            end
         end
      end
   end

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      edge_n       = 0;
      last_acc     = 0;
      step         = 32'd0;
      i_count      = 32'd0;
      rst          = 1'b1;
      wb.i_wb_cyc  = 1'b0;
      wb.i_wb_stb  = 1'b0;
      wb.i_wb_we   = 1'b0;
      wb.i_wb_addr = 30'd0;
      wb.i_wb_data = 32'd0;
      wb.i_wb_sel  = 4'hF;

      // Reset state
      repeat (3) cycle();
      rst = 1'b0;
      chk("rst_ack", {31'd0, wb.o_wb_ack}, 32'd0);
      chk("rst_stall", {31'd0, wb.o_wb_stall}, 32'd0);
      chk("rst_data", wb.o_wb_data, 32'd0);
      chk("rst_int", {31'd0, o_int}, 32'd0);
      rd(2'd0, 32'd0, "rst_ctrl");
      rd(2'd1, 32'd100000, "rst_period");
      rd(2'd2, 32'd0, "rst_vel");
      rd(2'd3, 32'd0, "rst_status");

      // Ramp +1/cycle, window 10: first sample exactly 10 edges after enable
      wr(2'd1, 32'd10, "wr_period10");
      step = 32'd1;
      wr(2'd0, 32'd3, "wr_ctrl_en");
      ebase = last_acc;
      goto(ebase + 9);
      chk("ramp_int_before", {31'd0, o_int}, 32'd0);
      goto(ebase + 10);
      chk("ramp_int_at", {31'd0, o_int}, 32'd1);
      rd(2'd2, 32'd10, "ramp_vel1");
      chk("ramp_int_cleared", {31'd0, o_int}, 32'd0);
      rd(2'd3, 32'd0, "ramp_status");
      goto(ebase + 19);
      chk("ramp_int_before2", {31'd0, o_int}, 32'd0);
      goto(ebase + 20);
      chk("ramp_int_at2", {31'd0, o_int}, 32'd1);
      rd(2'd2, 32'd10, "ramp_vel2");

      // Count wraps through zero inside the window
      wr(2'd0, 32'd0, "wr_ctrl_dis");
      i_count = 32'hFFFF_FFFB;
      wr(2'd0, 32'd3, "wr_ctrl_en_wrap");
      ebase = last_acc;
      goto(ebase + 10);
      rd(2'd2, 32'd10, "wrap_vel");

      // Constant count
      wr(2'd0, 32'd0, "wr_ctrl_dis2");
      step = 32'd0;
      wr(2'd0, 32'd3, "wr_ctrl_en_const");
      ebase = last_acc;
      goto(ebase + 10);
      rd(2'd2, 32'd0, "const_vel");

      // Decrease by 3 per window
      wr(2'd0, 32'd0, "wr_ctrl_dis3");
      wr(2'd0, 32'd3, "wr_ctrl_en_dec");
      ebase = last_acc;
      goto(ebase + 5);
      i_count = i_count - 32'd3;
      goto(ebase + 10);
      rd(2'd2, 32'hFFFF_FFFD, "dec_vel1");
      goto(ebase + 15);
      i_count = i_count - 32'd3;
      goto(ebase + 20);
      rd(2'd2, 32'hFFFF_FFFD, "dec_vel2");

      // Two unread samples -> overrun; W1C; reading VELOCITY clears valid
      goto(ebase + 40);
      rd(2'd3, 32'd3, "ovr_status");
      wr(2'd3, 32'd3, "ovr_w1c");
      rd(2'd3, 32'd0, "ovr_status_clr");
      goto(ebase + 50);
      chk("valid_int", {31'd0, o_int}, 32'd1);
      rd(2'd3, 32'd1, "valid_status");
      rd(2'd2, 32'd0, "valid_vel");
      rd(2'd3, 32'd0, "valid_status_clr");

      // PERIOD clamp and mid-window change
      wr(2'd0, 32'd0, "wr_ctrl_dis4");
      wr(2'd1, 32'd0, "wr_period0");
      rd(2'd1, 32'd2, "period_clamp");
      wr(2'd1, 32'd10, "wr_period10b");
      step = 32'd1;
      wr(2'd0, 32'd3, "wr_ctrl_en_per");
      ebase = last_acc;
      goto(ebase + 3);
      wr(2'd1, 32'd20, "wr_period20");
      rd(2'd1, 32'd20, "period20");
      goto(ebase + 9);
      chk("per_int_before", {31'd0, o_int}, 32'd0);
      goto(ebase + 10);
      chk("per_int_at", {31'd0, o_int}, 32'd1);
      rd(2'd2, 32'd10, "per_vel_old");
      goto(ebase + 29);
      chk("per_int_before20", {31'd0, o_int}, 32'd0);
      goto(ebase + 30);
      chk("per_int_at20", {31'd0, o_int}, 32'd1);
      rd(2'd2, 32'd20, "per_vel_new");
      goto(ebase + 50);
      chk("pre_rst_int", {31'd0, o_int}, 32'd1);

      // Reset during the ack cycle, mid-window with a pending sample
      begin
         exp_t x;
         x.dc  = 1'b0;
         x.val = 32'd20;
         x.nm  = "rst_inflight";
         exp_q.push_back(x);
      end
      wb.i_wb_cyc  = 1'b1;
      wb.i_wb_stb  = 1'b1;
      wb.i_wb_we   = 1'b0;
      wb.i_wb_addr = 30'd1;
      cycle();
      wb.i_wb_cyc  = 1'b0;
      wb.i_wb_stb  = 1'b0;
      rst = 1'b1;
      cycle();
      chk("mrst_ack", {31'd0, wb.o_wb_ack}, 32'd0);
      chk("mrst_stall", {31'd0, wb.o_wb_stall}, 32'd0);
      chk("mrst_data", wb.o_wb_data, 32'd0);
      chk("mrst_int", {31'd0, o_int}, 32'd0);
      rst = 1'b0;
      rd(2'd0, 32'd0, "mrst_ctrl");
      rd(2'd1, 32'd100000, "mrst_period");
      rd(2'd2, 32'd0, "mrst_vel");
      rd(2'd3, 32'd0, "mrst_status");

      repeat (3) cycle();
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
